// File: rtl/sdram_aref_arbiter.sv
// sdram_aref_arbiter: owns the SDRAM pins and grants them either to the
// refresh sequence or to the read/write access engine. Refresh has priority.
// The selected command, address and bank are registered onto the pins.
//
// Ports:
//   Clk, Rest          clock, asynchronous active-low reset
//   ArefReq/Cmd/Mode   refresh generator request and command/address stream
//   ArefDone           refresh sequence finished (1-cycle pulse)
//   SdramGetS          1-cycle start pulse back to the refresh generator
//   AccReq/AccGnt      access engine request and grant (level)
//   AccCmd/Addr/Ba     access command stream, used only while granted
//   AccDone            access burst finished (1-cycle pulse)
//   SdramCmd/Addr/Ba   registered SDRAM pins
//   ArefConflict       sticky: refresh command seen outside AREF
//   AccTimeout         sticky: access grant held longer than ACCMAXCYC
//   ArefCount          completed refreshes, wrapping
module sdram_aref_arbiter #(
    parameter int unsigned ACCMAXCYC = 12,
    parameter int unsigned CNTW      = 16
) (
    input  logic            Clk,
    input  logic            Rest,
    input  logic            ArefReq,
    input  logic [3:0]      ArefCmd,
    input  logic [12:0]     ArefMode,
    input  logic            ArefDone,
    output logic            SdramGetS,
    input  logic            AccReq,
    output logic            AccGnt,
    input  logic [3:0]      AccCmd,
    input  logic [12:0]     AccAddr,
    input  logic [1:0]      AccBa,
    input  logic            AccDone,
    output logic [3:0]      SdramCmd,
    output logic [12:0]     SdramAddr,
    output logic [1:0]      SdramBa,
    output logic            ArefConflict,
    output logic            AccTimeout,
    output logic [CNTW-1:0] ArefCount
);

    localparam int unsigned CMDW  = 4;
    localparam int unsigned ADDRW = 13;
    localparam int unsigned BAW   = 2;
    // Counter is wide enough to reach ACCMAXCYC+1 and then saturates.
    localparam int unsigned CYCW  = $clog2(ACCMAXCYC + 2);

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [CMDW-1:0] NOPC = 4'b0111;

    typedef struct packed {
        logic [CMDW-1:0]  cmd;
        logic [ADDRW-1:0] addr;
        logic [BAW-1:0]   ba;
    } pin_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        AREF = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            get_s_q, get_s_d;
    logic            gnt_q, gnt_d;
    pin_t            pin_q, pin_d;
    logic            conflict_q, conflict_d;
    logic            timeout_q, timeout_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CYCW-1:0] cyc_q, cyc_d;

    // State and output registers
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q    <= IDLE;
            get_s_q    <= 1'b0;
            gnt_q      <= 1'b0;
            pin_q      <= '{cmd: NOPC, addr: '0, ba: '0};
            conflict_q <= 1'b0;
            timeout_q  <= 1'b0;
            count_q    <= '0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            get_s_q    <= get_s_d;
            gnt_q      <= gnt_d;
            pin_q      <= pin_d;
            conflict_q <= conflict_d;
            timeout_q  <= timeout_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
        end
    end

    // Next-state, grant, pin mux and status
    always_comb begin
        state_d    = state_q;
        get_s_d    = 1'b0;
        gnt_d      = 1'b0;
        cyc_d      = cyc_q;
        conflict_d = conflict_q;
        timeout_d  = timeout_q;
        count_d    = count_q;
        pin_d      = '{cmd: NOPC, addr: '0, ba: '0};

        unique case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (ArefReq) begin
                    state_d = AREF;
                    get_s_d = 1'b1;
                end else if (AccReq) begin
                    state_d = ACC;
                    gnt_d   = 1'b1;
                    cyc_d   = CYCW'(1);
                end
            end
            ACC: begin
                gnt_d = 1'b1;
                // Overrun is only flagged; the engine keeps the pins.
                if (cyc_q > CYCW'(ACCMAXCYC)) begin
                    timeout_d = 1'b1;
                end
                if (cyc_q != '1) begin
                    cyc_d = cyc_q + CYCW'(1);
                end
                if (AccDone) begin
                    state_d = IDLE;
                    gnt_d   = 1'b0;
                    cyc_d   = '0;
                end
            end
            AREF: begin
                if (ArefDone) begin
                    state_d = IDLE;
                    count_d = count_q + CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A live refresh command always reaches the pins, whatever the state.
        if (ArefCmd != NOPC) begin
            pin_d = '{cmd: ArefCmd, addr: ArefMode, ba: '0};
            if (state_q != AREF) begin
                conflict_d = 1'b1;
            end
        end else if (state_q == ACC) begin
            pin_d = '{cmd: AccCmd, addr: AccAddr, ba: AccBa};
        end
    end

    assign SdramGetS    = get_s_q;
    assign AccGnt       = gnt_q;
    assign SdramCmd     = pin_q.cmd;
    assign SdramAddr    = pin_q.addr;
    assign SdramBa      = pin_q.ba;
    assign ArefConflict = conflict_q;
    assign AccTimeout   = timeout_q;
    assign ArefCount    = count_q;

endmodule

// File: tb/tb_sdram_aref_arbiter.sv
// Directed bench for sdram_aref_arbiter: a per-cycle vector table plus
// hand-written sequences for timeout, mid-grant reset and counter wrap.
module tb_sdram_aref_arbiter;

    localparam int unsigned CNTW = 8;

    localparam logic [3:0] N   = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] AR  = 4'b0001;

    logic            Clk = 1'b0;
    logic            Rest;
    logic            ArefReq, ArefDone, AccReq, AccDone;
    logic [3:0]      ArefCmd, AccCmd;
    logic [12:0]     ArefMode, AccAddr;
    logic [1:0]      AccBa;
    logic            SdramGetS, AccGnt, ArefConflict, AccTimeout;
    logic [3:0]      SdramCmd;
    logic [12:0]     SdramAddr;
    logic [1:0]      SdramBa;
    logic [CNTW-1:0] ArefCount;

    int checks = 0;
    int errors = 0;

    sdram_aref_arbiter #(.ACCMAXCYC(12), .CNTW(CNTW)) dut (
        .Clk(Clk), .Rest(Rest),
        .ArefReq(ArefReq), .ArefCmd(ArefCmd), .ArefMode(ArefMode),
        .ArefDone(ArefDone), .SdramGetS(SdramGetS),
        .AccReq(AccReq), .AccGnt(AccGnt), .AccCmd(AccCmd),
        .AccAddr(AccAddr), .AccBa(AccBa), .AccDone(AccDone),
        .SdramCmd(SdramCmd), .SdramAddr(SdramAddr), .SdramBa(SdramBa),
        .ArefConflict(ArefConflict), .AccTimeout(AccTimeout),
        .ArefCount(ArefCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic            areq;
        logic [3:0]      acmd;
        logic [12:0]     amode;
        logic            adone;
        logic            creq;
        logic [3:0]      ccmd;
        logic [12:0]     caddr;
        logic [1:0]      cba;
        logic            cdone;
        logic            e_gets;
        logic            e_gnt;
        logic [3:0]      e_cmd;
        logic [12:0]     e_addr;
        logic [1:0]      e_ba;
        logic            e_conf;
        logic            e_tmo;
        logic [CNTW-1:0] e_cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic areq, input logic [3:0] acmd, input logic [12:0] amode,
        input logic adone, input logic creq, input logic [3:0] ccmd,
        input logic [12:0] caddr, input logic [1:0] cba, input logic cdone,
        input logic gets, input logic gnt, input logic [3:0] cmd,
        input logic [12:0] addr, input logic [1:0] ba, input logic conf,
        input logic tmo, input logic [CNTW-1:0] cnt);
        vec_t v;
        v.areq = areq;  v.acmd = acmd;  v.amode = amode; v.adone = adone;
        v.creq = creq;  v.ccmd = ccmd;  v.caddr = caddr; v.cba = cba;
        v.cdone = cdone;
        v.e_gets = gets; v.e_gnt = gnt; v.e_cmd = cmd; v.e_addr = addr;
        v.e_ba = ba; v.e_conf = conf; v.e_tmo = tmo; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic gets, input logic gnt,
                           input logic [3:0] cmd, input logic [12:0] addr,
                           input logic [1:0] ba, input logic conf,
                           input logic tmo, input logic [CNTW-1:0] cnt);
        chk({tag, " SdramGetS"},    32'(SdramGetS),    32'(gets));
        chk({tag, " AccGnt"},       32'(AccGnt),       32'(gnt));
        chk({tag, " SdramCmd"},     32'(SdramCmd),     32'(cmd));
        chk({tag, " SdramAddr"},    32'(SdramAddr),    32'(addr));
        chk({tag, " SdramBa"},      32'(SdramBa),      32'(ba));
        chk({tag, " ArefConflict"}, 32'(ArefConflict), 32'(conf));
        chk({tag, " AccTimeout"},   32'(AccTimeout),   32'(tmo));
        chk({tag, " ArefCount"},    32'(ArefCount),    32'(cnt));
    endtask

    task automatic idle_inputs();
        ArefReq = 1'b0; ArefCmd = N; ArefMode = '0; ArefDone = 1'b0;
        AccReq = 1'b0;  AccCmd = N;  AccAddr = '0;  AccBa = '0; AccDone = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Enter ACC, hold it for k grant cycles, AccDone on the k-th.
    task automatic acc_burst(input int k);
        AccReq = 1'b1;
        step();
        AccReq = 1'b0;
        for (int j = 1; j <= k; j++) begin
            AccDone = (j == k);
            step();
            if (j == k - 1) chk($sformatf("burst%0d gnt held", k), 32'(AccGnt), 32'd1);
        end
        AccDone = 1'b0;
    endtask

    initial begin
        //         areq acmd amode    adone creq ccmd caddr     cba cdone | gets gnt cmd  addr     ba conf tmo cnt
        vecs[0]  = mk(0, N,   13'h0,   0,   0,  N,  13'h0,    0,  0,      0,   0,  N,   13'h0,   0, 0,   0,  0);
        vecs[1]  = mk(0, N,   13'h0,   0,   1,  N,  13'h0,    0,  0,      0,   1,  N,   13'h0,   0, 0,   0,  0);
        vecs[2]  = mk(0, N,   13'h0,   0,   1,  ACT,13'h123,  2,  0,      0,   1,  ACT, 13'h123, 2, 0,   0,  0);
        vecs[3]  = mk(0, N,   13'h0,   0,   1,  RD, 13'h400,  2,  0,      0,   1,  RD,  13'h400, 2, 0,   0,  0);
        vecs[4]  = mk(0, N,   13'h0,   0,   1,  N,  13'h0,    0,  1,      0,   0,  N,   13'h0,   0, 0,   0,  0);
        vecs[5]  = mk(0, N,   13'h0,   0,   1,  WR, 13'h5,    1,  0,      0,   1,  N,   13'h0,   0, 0,   0,  0);
        vecs[6]  = mk(1, N,   13'h0,   0,   1,  WR, 13'h5,    1,  0,      0,   1,  WR,  13'h5,   1, 0,   0,  0);
        vecs[7]  = mk(1, N,   13'h0,   0,   1,  N,  13'h0,    0,  1,      0,   0,  N,   13'h0,   0, 0,   0,  0);
        vecs[8]  = mk(1, N,   13'h0,   0,   1,  N,  13'h0,    0,  0,      1,   0,  N,   13'h0,   0, 0,   0,  0);
        vecs[9]  = mk(1, PRE, 13'h400, 0,   1,  N,  13'h0,    0,  0,      0,   0,  PRE, 13'h400, 0, 0,   0,  0);
        vecs[10] = mk(1, AR,  13'h0,   0,   1,  RD, 13'h7,    3,  0,      0,   0,  AR,  13'h0,   0, 0,   0,  0);
        vecs[11] = mk(0, N,   13'h0,   1,   1,  RD, 13'h7,    3,  0,      0,   0,  N,   13'h0,   0, 0,   0,  1);
        vecs[12] = mk(0, N,   13'h0,   0,   1,  RD, 13'h7,    3,  0,      0,   1,  N,   13'h0,   0, 0,   0,  1);
        vecs[13] = mk(0, AR,  13'h0,   0,   1,  RD, 13'h7,    3,  0,      0,   1,  AR,  13'h0,   0, 1,   0,  1);
        vecs[14] = mk(0, N,   13'h0,   0,   1,  N,  13'h0,    0,  1,      0,   0,  N,   13'h0,   0, 1,   0,  1);
        vecs[15] = mk(0, N,   13'h0,   1,   0,  N,  13'h0,    0,  0,      0,   0,  N,   13'h0,   0, 1,   0,  1);
        vecs[16] = mk(0, PRE, 13'h400, 0,   0,  N,  13'h0,    0,  0,      0,   0,  PRE, 13'h400, 0, 1,   0,  1);

        idle_inputs();
        Rest = 1'b0;
        step();
        step();
        chk_all("reset", 0, 0, N, 13'h0, 0, 0, 0, 0);
        Rest = 1'b1;

        for (int i = 0; i < NV; i++) begin
            ArefReq = vecs[i].areq;  ArefCmd = vecs[i].acmd;
            ArefMode = vecs[i].amode; ArefDone = vecs[i].adone;
            AccReq = vecs[i].creq;   AccCmd = vecs[i].ccmd;
            AccAddr = vecs[i].caddr; AccBa = vecs[i].cba; AccDone = vecs[i].cdone;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_gets, vecs[i].e_gnt,
                    vecs[i].e_cmd, vecs[i].e_addr, vecs[i].e_ba,
                    vecs[i].e_conf, vecs[i].e_tmo, vecs[i].e_cnt);
        end
        idle_inputs();

        // Exactly ACCMAXCYC grant cycles: no timeout.
        acc_burst(12);
        chk("burst12 timeout", 32'(AccTimeout), 32'd0);
        chk("burst12 gnt off", 32'(AccGnt), 32'd0);
        step();
        // One cycle more: timeout, sticky after release.
        acc_burst(13);
        chk("burst13 timeout", 32'(AccTimeout), 32'd1);
        chk("burst13 gnt off", 32'(AccGnt), 32'd0);
        repeat (3) step();
        chk("timeout sticky", 32'(AccTimeout), 32'd1);

        // Asynchronous reset in the middle of a grant.
        AccReq = 1'b1;
        step();
        chk("pre-reset gnt", 32'(AccGnt), 32'd1);
        #2;
        Rest = 1'b0;
        #1;
        chk_all("mid-acc reset", 0, 0, N, 13'h0, 0, 0, 0, 0);
        AccReq = 1'b0;
        Rest = 1'b1;
        step();
        chk("post-reset idle gnt", 32'(AccGnt), 32'd0);
        chk("post-reset idle cmd", 32'(SdramCmd), 32'(N));

        // Back-to-back refreshes: count 2^CNTW and wrap to zero.
        ArefReq = 1'b1;
        ArefDone = 1'b1;
        repeat (2 * ((1 << CNTW) - 1)) step();
        chk("count at max", 32'(ArefCount), 32'((1 << CNTW) - 1));
        repeat (2) step();
        chk("count wrapped", 32'(ArefCount), 32'd0);
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
